block_memory_responder: RTL and testbench
=========================================

Name: block_memory_responder

Overview:
Main-memory responder on the cache's refill side: the memory end of the cache↔memory block-transfer interface.
- Accepts one block read or block write request at a time from the cache controller.
- Holds mem_busywait high for a programmable access latency, then completes the transfer.
- Stores whole cache blocks (2**offset_size words of line_size bits) in an internal array indexed by block address.

Parameters:
- line_size, 32, word width in bits.
- offset_size, 2, log2 of words per block; block width = line_size * 2**offset_size (default 128).
- addr_bits, 8, block address width; memory depth = 2**addr_bits blocks.
- latency, 4, BUSY cycles per access; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- mem_read  input  1  block read request, level, held by the cache until busywait falls.
- mem_write  input  1  block write request, level, held by the cache until busywait falls.
- mem_address  input  addr_bits  block address.
- mem_writedata  input  line_size*2**offset_size  block to write; word 0 in the LSBs.
- mem_readdata  output  line_size*2**offset_size  block read result; word 0 in the LSBs.
- mem_busywait  output  1  stall to the cache.

Behaviour:
- Reset (reset==0, async, overrides everything):
  - state=IDLE, counter=0, mem_readdata=0, latched op/address/data cleared.
  - mem_busywait=0 immediately.
  - Memory array contents are NOT cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_busywait = mem_read | mem_write, combinational, so the cache stalls in the request cycle.
  - On a clk edge with a request present: latch mem_address, mem_writedata and op; counter<=latency-1; go to BUSY.
- BUSY:
  - mem_busywait=1; counter decrements each edge.
  - On the edge with counter==0, perform the access:
    - read: mem_readdata <= array[addr].
    - write: array[addr] <= wdata.
  - Then go to DONE.
  - Input changes during BUSY are ignored; latched values are used.
- DONE:
  - mem_busywait=0 for exactly one cycle; mem_readdata is valid.
  - Requests are ignored in this cycle (the cache drops its request here).
  - Next edge → IDLE.
- Timing: request visible in cycle 0 → busywait high for latency+1 cycles (cycle 0 plus latency BUSY cycles) → low in DONE, i.e. cycle latency+1. Next request is accepted from cycle latency+2.
- mem_readdata holds its last read value across writes and idle periods; it changes only on read completion or reset.
- Simultaneous mem_read and mem_write: treated as a write; mem_readdata is unchanged.
- Reset mid-BUSY aborts the access: a pending write is not committed and mem_readdata returns to 0.
- Address wrap: not applicable; mem_address spans the full array.
- Array write is synchronous; no read-during-write hazard exists because one access is in flight at a time.

Test Plan:
1. reset=0 for 3 cycles, then 1 → mem_busywait=0, mem_readdata=0, no spurious busy with mem_read=mem_write=0.
2. Write addr 0x09, data {32'h3,32'h2,32'h1,32'h0}, latency=4 → busywait=1 in cycles 0–4, 0 in cycle 5; back to IDLE in cycle 6.
3. Read addr 0x09 after test 2 → busywait=1 for 5 cycles; mem_readdata=128'h00000003_00000002_00000001_00000000 in DONE, held afterwards.
4. mem_read=mem_write=1 at addr 0x0A with data all-F → subsequent read of 0x0A returns all-F; mem_readdata unchanged during the combined request.
5. Write 0x0B=all-A, then write 0x0B=all-5 with reset pulsed low in BUSY cycle 2 → busywait drops asynchronously and mem_readdata=0; a following read of 0x0B returns all-A.
6. Cache holds mem_read through DONE, then issues a new read of 0x09 → the DONE-cycle request is ignored; the new request is accepted from cycle latency+2 and completes with the correct data.

Source files
------------

// File: rtl/block_memory_responder.sv
// ============================================================================
// Module      : block_memory_responder
// Description : Main-memory end of the cache refill interface; serves one
//               block read or write at a time after a fixed access latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_memory_responder #(
  parameter int LINE_SIZE   = 32,
  parameter int OFFSET_SIZE = 2,
  parameter int ADDR_BITS   = 8,
  parameter int LATENCY     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  input  logic [ADDR_BITS-1:0]                  mem_address,
  input  logic [LINE_SIZE*(2**OFFSET_SIZE)-1:0] mem_writedata,
  output logic [LINE_SIZE*(2**OFFSET_SIZE)-1:0] mem_readdata,
  output logic                                  mem_busywait
);

  localparam int BLOCK_W = LINE_SIZE * (2**OFFSET_SIZE);
  localparam int DEPTH   = 2**ADDR_BITS;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     counter;
  logic [ADDR_BITS-1:0] addr_q;
  logic [BLOCK_W-1:0]   wdata_q;
  logic                 is_write;
  logic                 access_now;
  logic [BLOCK_W-1:0]   mem_array [0:DEPTH-1];

  assign access_now = (state == BUSY) && (counter == '0);

  always_comb begin
    state_d      = state;
    mem_busywait = 1'b0;
    case (state)
      IDLE: begin
        mem_busywait = mem_read | mem_write;
        if (mem_read | mem_write) state_d = BUSY;
      end
      BUSY: begin
        mem_busywait = 1'b1;
        if (counter == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset must drop the stall immediately, even with a request present.
    if (!reset) mem_busywait = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write     <= 1'b0;
      mem_readdata <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (mem_read | mem_write) begin
            addr_q   <= mem_address;
            wdata_q  <= mem_writedata;
            is_write <= mem_write;
            counter  <= CNT_W'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (counter != '0) counter <= counter - 1'b1;
          else if (!is_write) mem_readdata <= mem_array[addr_q];
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; an aborted access leaves state IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if (access_now && is_write && reset) mem_array[addr_q] <= wdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_block_memory_responder.sv
// ============================================================================
// Module      : tb_block_memory_responder
// Description : Directed self-checking bench for block_memory_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_memory_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [7:0]   mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int total;
  int bad;

  localparam logic [127:0] B09  = 128'h00000003_00000002_00000001_00000000;
  localparam logic [127:0] ALLF = {128{1'b1}};
  localparam logic [127:0] ALLA = {32{4'hA}};
  localparam logic [127:0] ALL5 = {32{4'h5}};

  block_memory_responder #(
    .LINE_SIZE  (32),
    .OFFSET_SIZE(2),
    .ADDR_BITS  (8),
    .LATENCY    (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request and check cycles 0..LAT+1; the request stays asserted on return.
  task automatic run_req(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [127:0] d, input logic [127:0] prev_rd,
                         input logic [127:0] exp_rd);
    @(posedge clk); #1;
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = a;
    mem_writedata = d;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", k), {127'd0, mem_busywait}, 128'd1);
      check($sformatf("rdata_hold_c%0d", k), mem_readdata, prev_rd);
      @(posedge clk); #1;
      if (k == 1) begin
        mem_address   = a ^ 8'h01;
        mem_writedata = ~d;
      end
      if (k == 2) begin
        mem_address   = a;
        mem_writedata = d;
      end
    end
    @(negedge clk);
    check("done_busy", {127'd0, mem_busywait}, 128'd0);
    check("done_rdata", mem_readdata, exp_rd);
  endtask

  task automatic idle_cycle(input logic [127:0] exp_rd);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("idle_busy", {127'd0, mem_busywait}, 128'd0);
    check("idle_rdata", mem_readdata, exp_rd);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;

    // Test 1: reset, including a request seen while reset is held.
    repeat (2) @(posedge clk);
    #1 mem_read = 1'b1;
    @(negedge clk);
    check("rst_busy_req", {127'd0, mem_busywait}, 128'd0);
    check("rst_rdata", mem_readdata, 128'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {127'd0, mem_busywait}, 128'd0);
    check("post_rst_rdata", mem_readdata, 128'd0);

    // Test 2: write 0x09.
    run_req(1'b0, 1'b1, 8'h09, B09, 128'd0, 128'd0);
    idle_cycle(128'd0);

    // Test 3: read 0x09.
    run_req(1'b1, 1'b0, 8'h09, 128'd0, 128'd0, B09);
    idle_cycle(B09);

    // Test 4: combined read+write acts as a write.
    run_req(1'b1, 1'b1, 8'h0A, ALLF, B09, B09);
    idle_cycle(B09);
    run_req(1'b1, 1'b0, 8'h0A, 128'd0, B09, ALLF);
    idle_cycle(ALLF);

    // Test 5: write aborted by reset mid-BUSY leaves the old block intact.
    run_req(1'b0, 1'b1, 8'h0B, ALLA, ALLF, ALLF);
    idle_cycle(ALLF);
    @(posedge clk); #1;
    mem_write     = 1'b1;
    mem_address   = 8'h0B;
    mem_writedata = ALL5;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {127'd0, mem_busywait}, 128'd0);
    check("abort_rdata", mem_readdata, 128'd0);
    mem_write = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", {127'd0, mem_busywait}, 128'd0);
    run_req(1'b1, 1'b0, 8'h0B, 128'd0, 128'd0, ALLA);
    idle_cycle(ALLA);

    // Test 6: request held through DONE, then a new read accepted at LAT+2.
    run_req(1'b1, 1'b0, 8'h0A, 128'd0, ALLA, ALLF);
    run_req(1'b1, 1'b0, 8'h09, 128'd0, ALLF, B09);
    idle_cycle(B09);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
